div_fma16: RTL
==============

DIV_FMA16 -- requirements
Module: div_fma16

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request a division; accepted only when busy=0.
REQ-004 The block SHALL have the ports x and y, input, 16 bits each: IEEE-754 binary16 dividend and divisor, sampled on the accepting edge.
REQ-005 The block SHALL have the port busy, output, 1 bit: an operation is in flight.
REQ-006 The block SHALL have the port done, output, 1 bit: one-cycle pulse marking that result and the flags are valid.
REQ-007 The block SHALL have the port result, output, 16 bits: binary16 quotient, held until the next accepted start.
REQ-008 The block SHALL have the ports invalid, divzero, overflow and underflow, output, 1 bit each: exception flags, valid and held like result.

Function
REQ-009 The block SHALL use an FSM with states IDLE, DIV, NORM and DONE.
REQ-010 IDLE SHALL go to DIV when start=1, latching x and y.
REQ-011 DIV SHALL run exactly 12 iterations and then go to NORM.
REQ-012 NORM SHALL take one cycle and then go to DONE.
REQ-013 DONE SHALL last one cycle and then go to IDLE.
REQ-014 Latency SHALL be fixed: start accepted at edge T gives busy=1 from T+1 to T+13, and at T+14 done=1 with busy=0.
REQ-015 A start at the T+14 edge SHALL be accepted, giving back-to-back operation.
REQ-016 start while busy=1 SHALL be ignored, and changes on x and y after acceptance SHALL have no effect.
REQ-017 Mantissas SHALL be mx={1,x[9:0]} and my={1,y[9:0]}; an exponent field of 0 (zero or subnormal) SHALL be treated as zero (flush-to-zero input).
REQ-018 DIV SHALL be a restoring divide with one quotient bit per cycle, giving a 12-bit q = floor(mx*2^11/my), with q[11] having weight 2^0.
REQ-019 NORM, when q[11]=1, SHALL set frac=q[10:1] and e=ex-ey+15.
REQ-020 NORM, when q[11]=0, SHALL set frac=q[9:0] and e=ex-ey+14.
REQ-021 e SHALL be a 7-bit signed value.
REQ-022 Rounding SHALL be toward zero (truncation); no sticky or inexact output.
REQ-023 When e>=31, result SHALL be signed infinity with overflow=1.
REQ-024 When e<=0, result SHALL be signed zero with underflow=1 (flush-to-zero output).
REQ-025 The sign SHALL be x[15]^y[15] for every non-NaN result.
REQ-026 A NaN operand, 0/0 or inf/inf SHALL give 0x7E00 with invalid=1.
REQ-027 Finite nonzero divided by 0 SHALL give signed infinity with divzero=1.
REQ-028 inf/finite SHALL give signed infinity with no flags raised.
REQ-029 finite/inf and 0/nonzero SHALL give signed zero with no flags raised.
REQ-030 Special cases SHALL be detected at acceptance but still reported at T+14, so latency is operand-independent.
REQ-031 At most one flag SHALL be set per result.
REQ-032 Flags SHALL be cleared when a new start is accepted.

Reset
REQ-033 On reset the FSM SHALL enter IDLE immediately, with busy=0, done=0, result=0x0000 and all flags 0.
REQ-034 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-035 The first start after reset is released SHALL behave per REQ-014.

Structure
REQ-036 Package fma16_pkg SHALL hold the FSM state enum, BIAS=15, ITER=12, QNAN=16'h7E00, the infinity exponent 5'b11111 and the binary16 field-slice widths.
REQ-037 Sub-module divstep_fma16 SHALL be a combinational single restoring-division step: remainder in, divisor in, next remainder and quotient bit out.
REQ-038 All registers, including the FSM, iteration counter, remainder and quotient, SHALL live in div_fma16.

Verification
REQ-039 The bench SHALL check x=0x4200 (3.0), y=0x3E00 (1.5) -> result 0x4000, no flags, done exactly at T+14.
REQ-040 The bench SHALL check x=0x3C00, y=0x4200 -> 0x3555 (truncated 1/3).
REQ-041 The bench SHALL check x=0x3C00, y=0x0000 -> 0x7C00 with divzero=1.
REQ-042 The bench SHALL check x=0xBC00, y=0x0000 -> 0xFC00 with divzero=1.
REQ-043 The bench SHALL check x=0x0000, y=0x0000 -> 0x7E00 with invalid=1.
REQ-044 The bench SHALL check x=0x7BFF, y=0x3800 -> 0x7C00 with overflow=1.
REQ-045 The bench SHALL check x=0x0400, y=0x4000 -> 0x0000 with underflow=1.
REQ-046 The bench SHALL check that start held high for 20 cycles with x and y changing yields exactly one done, for the first operands, at T+14.
REQ-047 The bench SHALL check that reset asserted at T+6 produces no done and all outputs return to their reset values in the same cycle.

Source files
------------

// File: rtl/fma16_pkg.sv
// Shared types and constants for the binary16 iterative divider.
// Holds the FSM states, operand field slices and special-case codes.
package fma16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        SP_NONE    = 3'd0,
        SP_INVALID = 3'd1,
        SP_INF     = 3'd2,
        SP_DIVZERO = 3'd3,
        SP_ZERO    = 3'd4
    } special_t;

    localparam int          BIAS    = 15;
    localparam int          ITER    = 12;
    localparam logic [15:0] QNAN    = 16'h7E00;
    localparam logic [4:0]  EXP_INF = 5'b11111;

    localparam int SIGN_BIT = 15;
    localparam int EXP_W    = 5;
    localparam int EXP_LSB  = 10;
    localparam int FRAC_W   = 10;
    localparam int MANT_W   = FRAC_W + 1;
    localparam int REM_W    = MANT_W + 1;

endpackage

// File: rtl/divstep_fma16.sv
// One restoring-division step: subtract the divisor when it fits,
// emit the quotient bit and shift the remainder for the next step.
module divstep_fma16
    import fma16_pkg::*;
(
    input  logic [REM_W-1:0]  rem_i,
    input  logic [MANT_W-1:0] div_i,
    output logic [REM_W-1:0]  rem_o,
    output logic              q_o
);

    logic [REM_W-1:0] diff;

    always_comb begin
        diff  = rem_i - {1'b0, div_i};
        q_o   = (rem_i >= {1'b0, div_i});
        rem_o = (q_o ? diff : rem_i) << 1;
    end

endmodule

// File: rtl/div_fma16.sv
// Fixed-latency binary16 divider: 12-step restoring mantissa divide,
// truncating normalisation, flush-to-zero on inputs and outputs.
module div_fma16
    import fma16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        invalid,
    output logic        divzero,
    output logic        overflow,
    output logic        underflow
);

    state_t              state_q, state_d;
    special_t            spec_q, spec_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [MANT_W-1:0]   dsr_q, dsr_d;
    logic [ITER-1:0]     quo_q, quo_d;
    logic                sign_q, sign_d;
    logic signed [6:0]   ediff_q, ediff_d;
    logic [15:0]         result_q, result_d;
    logic [3:0]          flags_q, flags_d;

    logic [REM_W-1:0]    step_rem;
    logic                step_bit;

    logic [EXP_W-1:0]    x_exp, y_exp;
    logic                x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic signed [6:0]   e_norm;
    logic [FRAC_W-1:0]   frac_norm;

    divstep_fma16 u_step (
        .rem_i (rem_q),
        .div_i (dsr_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

    always_comb begin
        x_exp  = x[EXP_LSB +: EXP_W];
        y_exp  = y[EXP_LSB +: EXP_W];
        x_nan  = (x_exp == EXP_INF) && (x[FRAC_W-1:0] != '0);
        y_nan  = (y_exp == EXP_INF) && (y[FRAC_W-1:0] != '0);
        x_inf  = (x_exp == EXP_INF) && (x[FRAC_W-1:0] == '0);
        y_inf  = (y_exp == EXP_INF) && (y[FRAC_W-1:0] == '0);
        x_zero = (x_exp == '0);
        y_zero = (y_exp == '0);

        // q[11] set means the quotient is already in [1,2)
        if (quo_q[ITER-1]) begin
            frac_norm = quo_q[FRAC_W:1];
            e_norm    = ediff_q + 7'(BIAS);
        end else begin
            frac_norm = quo_q[FRAC_W-1:0];
            e_norm    = ediff_q + 7'(BIAS - 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        spec_d   = spec_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        quo_d    = quo_q;
        sign_d   = sign_q;
        ediff_d  = ediff_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = DIV;
                    cnt_d    = 4'(ITER);
                    rem_d    = {2'b01, x[FRAC_W-1:0]};
                    dsr_d    = {1'b1, y[FRAC_W-1:0]};
                    quo_d    = '0;
                    sign_d   = x[SIGN_BIT] ^ y[SIGN_BIT];
                    ediff_d  = $signed({2'b00, x_exp}) - $signed({2'b00, y_exp});
                    result_d = '0;
                    flags_d  = '0;
                    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
                        spec_d = SP_INVALID;
                    else if (x_inf)
                        spec_d = SP_INF;
                    else if (y_zero)
                        spec_d = SP_DIVZERO;
                    else if (y_inf || x_zero)
                        spec_d = SP_ZERO;
                    else
                        spec_d = SP_NONE;
                end
            end
            DIV: begin
                rem_d = step_rem;
                quo_d = {quo_q[ITER-2:0], step_bit};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
                // flags order: invalid, divzero, overflow, underflow
                case (spec_q)
                    SP_INVALID: begin
                        result_d = QNAN;
                        flags_d  = 4'b1000;
                    end
                    SP_INF: result_d = {sign_q, EXP_INF, 10'd0};
                    SP_DIVZERO: begin
                        result_d = {sign_q, EXP_INF, 10'd0};
                        flags_d  = 4'b0100;
                    end
                    SP_ZERO: result_d = {sign_q, 15'd0};
                    default: begin
                        if (e_norm >= 7'sd31) begin
                            result_d = {sign_q, EXP_INF, 10'd0};
                            flags_d  = 4'b0010;
                        end else if (e_norm <= 7'sd0) begin
                            result_d = {sign_q, 15'd0};
                            flags_d  = 4'b0001;
                        end else begin
                            result_d = {sign_q, e_norm[EXP_W-1:0], frac_norm};
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            spec_q   <= SP_NONE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            quo_q    <= '0;
            sign_q   <= 1'b0;
            ediff_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            spec_q   <= spec_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dsr_q    <= dsr_d;
            quo_q    <= quo_d;
            sign_q   <= sign_d;
            ediff_q  <= ediff_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy      = (state_q == DIV) || (state_q == NORM);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign invalid   = flags_q[3];
    assign divzero   = flags_q[2];
    assign overflow  = flags_q[1];
    assign underflow = flags_q[0];

endmodule
